// File: rtl/warp_scheduler.sv
// warp_scheduler: per-core control FSM. It steps each instruction through
// FETCH, DECODE, REQUEST, WAIT, EXECUTE and UPDATE, and publishes core_state
// and current_pc to the per-lane PC units, ALUs and LSUs. In UPDATE it picks
// the next core PC from the lowest-index enabled lane, flags lane divergence
// and retires the instruction. RET ends the block in the sticky DONE state.
module warp_scheduler #(
  parameter int THREADS = 4,
  parameter int PC_BITS = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [THREADS-1:0]         thread_enable,
  input  logic                       fetch_valid,
  input  logic [2*THREADS-1:0]       lsu_state,
  input  logic                       decoded_ret,
  input  logic [PC_BITS*THREADS-1:0] next_pc,
  output logic [2:0]                 core_state,
  output logic [PC_BITS-1:0]         current_pc,
  output logic                       done,
  output logic                       diverged,
  output logic [15:0]                instr_count
);

  // The downstream units decode these encodings directly, so they must not change.
  localparam logic [2:0] IDLE    = 3'b000;
  localparam logic [2:0] FETCH   = 3'b001;
  localparam logic [2:0] DECODE  = 3'b010;
  localparam logic [2:0] REQUEST = 3'b011;
  localparam logic [2:0] WAIT    = 3'b100;
  localparam logic [2:0] EXECUTE = 3'b101;
  localparam logic [2:0] UPDATE  = 3'b110;
  localparam logic [2:0] DONE    = 3'b111;

  localparam logic [1:0] LSU_REQUESTING = 2'b01;
  localparam logic [1:0] LSU_WAITING    = 2'b10;

  // Lane mask captured at launch; later changes on thread_enable are ignored.
  logic [THREADS-1:0] lane_mask;

  logic               any_busy;
  logic [PC_BITS-1:0] sel_pc;
  logic               pc_mismatch;

  // An enabled lane whose LSU is still requesting or waiting holds the core in WAIT.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
    any_busy = 1'b0;
    for (int i = 0; i < THREADS; i++) begin
      if (lane_mask[i] &&
          (lsu_state[2*i +: 2] == LSU_REQUESTING || lsu_state[2*i +: 2] == LSU_WAITING))
        any_busy = 1'b1;
    end
  end

  // Select next PC from the lowest-index enabled lane (lane 0 if none enabled);
  // scanning downward lets the lowest enabled lane win without an early exit.
  always_comb begin
    sel_pc = next_pc[PC_BITS-1:0];
    for (int i = THREADS - 1; i >= 0; i--) begin
      if (lane_mask[i])
        sel_pc = next_pc[PC_BITS*i +: PC_BITS];
    end
  end

  // Any enabled lane proposing a different next PC than the selected one is a divergence.
  always_comb begin
    pc_mismatch = 1'b0;
    for (int i = 0; i < THREADS; i++) begin
      if (lane_mask[i] && (next_pc[PC_BITS*i +: PC_BITS] != sel_pc))
        pc_mismatch = 1'b1;
    end
  end

  // Instruction sequencing FSM and all registered outputs; reset wins in every state.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      core_state  <= IDLE;
      current_pc  <= '0;
      done        <= 1'b0;
      diverged    <= 1'b0;
      instr_count <= '0;
      lane_mask   <= '0;
    end else begin
      case (core_state)
        IDLE: begin
          if (start) begin
            lane_mask  <= thread_enable;
            core_state <= FETCH;
          end
        end
        FETCH: begin
          if (fetch_valid)
            core_state <= DECODE;
        end
        DECODE:  core_state <= REQUEST;
        REQUEST: core_state <= WAIT;
        WAIT: begin
          if (!any_busy)
            core_state <= EXECUTE;
        end
        EXECUTE: core_state <= UPDATE;
        UPDATE: begin
          if (instr_count != 16'hFFFF)
            instr_count <= instr_count + 16'd1;
          if (pc_mismatch)
            diverged <= 1'b1;
          if (decoded_ret) begin
            done       <= 1'b1;
            core_state <= DONE;
          end else begin
            current_pc <= sel_pc;
            core_state <= FETCH;
          end
        end
        DONE:    core_state <= DONE;
        default: core_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_warp_scheduler.sv
// Self-checking bench for warp_scheduler (THREADS=4, PC_BITS=8). A table of
// per-instruction records drives fetch/LSU/next-PC stimulus; the expected
// state after each clock edge goes through a scoreboard queue, and the PC,
// divergence, count and done flags are compared after every UPDATE.
module tb_warp_scheduler;

  localparam int THREADS = 4;
  localparam int PC_BITS = 8;

  localparam logic [2:0] S_IDLE    = 3'b000;
  localparam logic [2:0] S_FETCH   = 3'b001;
  localparam logic [2:0] S_DECODE  = 3'b010;
  localparam logic [2:0] S_REQUEST = 3'b011;
  localparam logic [2:0] S_WAIT    = 3'b100;
  localparam logic [2:0] S_EXECUTE = 3'b101;
  localparam logic [2:0] S_UPDATE  = 3'b110;
  localparam logic [2:0] S_DONE    = 3'b111;

  logic                       clk = 1'b0;
  logic                       reset = 1'b1;
  logic                       start = 1'b0;
  logic [THREADS-1:0]         thread_enable = '0;
  logic                       fetch_valid = 1'b0;
  logic [2*THREADS-1:0]       lsu_state = '0;
  logic                       decoded_ret = 1'b0;
  logic [PC_BITS*THREADS-1:0] next_pc = '0;
  logic [2:0]                 core_state;
  logic [PC_BITS-1:0]         current_pc;
  logic                       done;
  logic                       diverged;
  logic [15:0]                instr_count;

  warp_scheduler #(.THREADS(THREADS), .PC_BITS(PC_BITS)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .thread_enable (thread_enable),
    .fetch_valid   (fetch_valid),
    .lsu_state     (lsu_state),
    .decoded_ret   (decoded_ret),
    .next_pc       (next_pc),
    .core_state    (core_state),
    .current_pc    (current_pc),
    .done          (done),
    .diverged      (diverged),
    .instr_count   (instr_count)
  );

  always #5 clk = ~clk;

  // One instruction: optional fresh launch, stall lengths, lane inputs and expected results.
  typedef struct {
    logic                       launch;
    logic [THREADS-1:0]         mask;
    int                         fetch_stall;
    int                         busy_lane;
    int                         busy_cycles;
    logic [2*THREADS-1:0]       lsu_bg;
    logic [PC_BITS*THREADS-1:0] npc;
    logic                       ret;
    int                         exp_wait;
    logic [PC_BITS-1:0]         exp_pc;
    logic                       exp_div;
    logic [15:0]                exp_cnt;
    logic                       exp_done;
  } vec_t;

  vec_t       vecs[11];
  logic [2:0] exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push the state the next edge should produce, clock, then pop and compare.
  task automatic expect_next(input logic [2:0] s, input string name);
    logic [2:0] e;
    exp_q.push_back(s);
    step();
    e = exp_q.pop_front();
    check(name, {29'd0, core_state}, {29'd0, e});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " core_state"},  {29'd0, core_state}, 32'd0);
    check({tag, " current_pc"},  {24'd0, current_pc}, 32'd0);
    check({tag, " done"},        {31'd0, done}, 32'd0);
    check({tag, " diverged"},    {31'd0, diverged}, 32'd0);
    check({tag, " instr_count"}, {16'd0, instr_count}, 32'd0);
  endtask

  // Reset, check reset values, launch with mask, then scramble thread_enable.
  task automatic do_launch(input logic [THREADS-1:0] mask);
    reset = 1'b1;
    start = 1'b0;
    fetch_valid = 1'b0;
    lsu_state = '0;
    step();
    step();
    check_reset_values("reset");
    reset = 1'b0;
    start = 1'b1;
    thread_enable = mask;
    expect_next(S_FETCH, "launch");
    start = 1'b0;
    thread_enable = ~mask;
  endtask

  // LSU pattern p cycles after REQUEST entry: busy lane shows 01 twice, then 10, then 11.
  function automatic logic [2*THREADS-1:0] lsu_at(input vec_t v, input int p);
    logic [2*THREADS-1:0] l;
    l = v.lsu_bg;
    if (v.busy_lane >= 0) begin
      if (p < 2)                  l[2*v.busy_lane +: 2] = 2'b01;
      else if (p < v.busy_cycles) l[2*v.busy_lane +: 2] = 2'b10;
      else                        l[2*v.busy_lane +: 2] = 2'b11;
    end
    return l;
  endfunction

  // Runs one instruction starting with the DUT in FETCH.
  task automatic apply(input vec_t v);
    if (v.launch) do_launch(v.mask);
    next_pc     = v.npc;
    decoded_ret = v.ret;
    lsu_state   = v.lsu_bg;
    for (int k = 0; k <= v.fetch_stall; k++) begin
      fetch_valid = (k == v.fetch_stall);
      expect_next((k == v.fetch_stall) ? S_DECODE : S_FETCH, "fetch");
    end
    fetch_valid = 1'b0;
    expect_next(S_REQUEST, "decode");
    lsu_state = lsu_at(v, 0);
    expect_next(S_WAIT, "request");
    for (int j = 0; j < v.exp_wait; j++) begin
      lsu_state = lsu_at(v, j + 1);
      expect_next((j == v.exp_wait - 1) ? S_EXECUTE : S_WAIT, "wait");
    end
    lsu_state = v.lsu_bg;
    expect_next(S_UPDATE, "execute");
    expect_next(v.ret ? S_DONE : S_FETCH, "update");
    check("current_pc",  {24'd0, current_pc}, {24'd0, v.exp_pc});
    check("diverged",    {31'd0, diverged}, {31'd0, v.exp_div});
    check("instr_count", {16'd0, instr_count}, {16'd0, v.exp_cnt});
    check("done",        {31'd0, done}, {31'd0, v.exp_done});
    decoded_ret = 1'b0;
  endtask

  initial begin
    vec_t v;
    // launch mask stall blane bcyc lsu_bg  npc           ret wait pc     div cnt  done
    vecs[0]  = '{1'b1, 4'hF, 0, -1, 0, 8'h00, 32'h01010101, 1'b0, 1, 8'h01, 1'b0, 16'd1, 1'b0};
    vecs[1]  = '{1'b0, 4'hF, 0, -1, 0, 8'h00, 32'h02020202, 1'b0, 1, 8'h02, 1'b0, 16'd2, 1'b0};
    vecs[2]  = '{1'b0, 4'hF, 0, -1, 0, 8'h00, 32'h03030303, 1'b1, 1, 8'h02, 1'b0, 16'd3, 1'b1};
    // fetch stall of 4 cycles, lane 2 LSU busy for five cycles from REQUEST
    vecs[3]  = '{1'b1, 4'hF, 4,  2, 5, 8'h00, 32'h05050505, 1'b0, 5, 8'h05, 1'b0, 16'd1, 1'b0};
    // masked lanes: lane 0 stuck waiting but disabled, lane 3 disabled
    vecs[4]  = '{1'b1, 4'h6, 0, -1, 0, 8'h02, 32'h77101055, 1'b0, 1, 8'h10, 1'b0, 16'd1, 1'b0};
    // divergence is sticky, then PC wraps FF -> 00
    vecs[5]  = '{1'b1, 4'hF, 0, -1, 0, 8'h00, 32'h21202020, 1'b0, 1, 8'h20, 1'b1, 16'd1, 1'b0};
    vecs[6]  = '{1'b0, 4'hF, 0, -1, 0, 8'h00, 32'h30303030, 1'b0, 1, 8'h30, 1'b1, 16'd2, 1'b0};
    vecs[7]  = '{1'b0, 4'hF, 0, -1, 0, 8'h00, 32'hFFFFFFFF, 1'b0, 1, 8'hFF, 1'b1, 16'd3, 1'b0};
    vecs[8]  = '{1'b0, 4'hF, 0, -1, 0, 8'h00, 32'h00000000, 1'b0, 1, 8'h00, 1'b1, 16'd4, 1'b0};
    // empty mask: every LSU busy but ignored, lane 0 PC used
    vecs[9]  = '{1'b1, 4'h0, 0, -1, 0, 8'hAA, 32'h44444433, 1'b0, 1, 8'h33, 1'b0, 16'd1, 1'b0};
    // RET still performs the divergence check and leaves current_pc alone
    vecs[10] = '{1'b1, 4'hF, 0, -1, 0, 8'h00, 32'h01010102, 1'b1, 1, 8'h00, 1'b1, 16'd1, 1'b1};

    for (int i = 0; i < 11; i++) apply(vecs[i]);

    // DONE is terminal: start is ignored.
    start = 1'b1;
    thread_enable = 4'hF;
    expect_next(S_DONE, "done sticky");
    expect_next(S_DONE, "done sticky");
    start = 1'b0;
    check("done held", {31'd0, done}, 32'd1);
    check("pc held in done", {24'd0, current_pc}, 32'h00);

    // Reset during WAIT, then a start in DECODE that must be ignored.
    do_launch(4'b1110);
    next_pc = 32'h42424299;
    fetch_valid = 1'b1;
    expect_next(S_DECODE, "mid fetch");
    fetch_valid = 1'b0;
    expect_next(S_REQUEST, "mid decode");
    lsu_state = 8'h20;
    expect_next(S_WAIT, "mid request");
    expect_next(S_WAIT, "mid wait hold");
    reset = 1'b1;
    step();
    check_reset_values("mid reset");
    reset = 1'b0;
    lsu_state = '0;
    step();
    check("idle without start", {29'd0, core_state}, {29'd0, S_IDLE});
    start = 1'b1;
    thread_enable = 4'b1110;
    expect_next(S_FETCH, "relaunch");
    start = 1'b0;
    fetch_valid = 1'b1;
    expect_next(S_DECODE, "relaunch fetch");
    fetch_valid = 1'b0;
    start = 1'b1;
    thread_enable = 4'b0001;
    expect_next(S_REQUEST, "start in decode");
    start = 1'b0;
    expect_next(S_WAIT, "relaunch request");
    expect_next(S_EXECUTE, "relaunch wait");
    expect_next(S_UPDATE, "relaunch execute");
    expect_next(S_FETCH, "relaunch update");
    check("relaunch pc", {24'd0, current_pc}, 32'h42);
    check("relaunch count", {16'd0, instr_count}, 32'd1);
    check("relaunch diverged", {31'd0, diverged}, 32'd0);

    // Saturation: preload the retired count at its ceiling.
    do_launch(4'hF);
    force dut.instr_count = 16'hFFFF;
    expect_next(S_FETCH, "preload");
    release dut.instr_count;
    check("preload count", {16'd0, instr_count}, 32'hFFFF);
    v = '{1'b0, 4'hF, 0, -1, 0, 8'h00, 32'h11111111, 1'b0, 1, 8'h11, 1'b0, 16'hFFFF, 1'b0};
    apply(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/warp_scheduler.md
Name: warp_scheduler

Overview:
- Per-core control FSM that sequences every instruction through FETCH, DECODE, REQUEST, WAIT, EXECUTE and UPDATE.
- Drives the shared `core_state` and `current_pc` buses that each per-thread PC unit, ALU and LSU consume.
- In UPDATE it collects the per-thread next-PC values, advances the core PC and retires the instruction.
- Terminates the block on RET and raises `done`.

Parameters:
- THREADS, 4, number of thread lanes in the core (1..8).
- PC_BITS, 8, program counter width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  launch pulse; sampled only in IDLE
- thread_enable  in  THREADS  active-lane mask; latched on accepted start
- fetch_valid  in  1  fetcher holds a valid instruction for current_pc
- lsu_state  in  2*THREADS  per-lane LSU state, lane i at [2i+1:2i]; 00 idle, 01 requesting, 10 waiting, 11 done
- decoded_ret  in  1  decoded instruction is RET
- next_pc  in  PC_BITS*THREADS  per-lane next PC, lane i at [PC_BITS*(i+1)-1 : PC_BITS*i]
- core_state  out  3  current FSM state
- current_pc  out  PC_BITS  PC of the instruction in flight
- done  out  1  block finished; sticky
- diverged  out  1  sticky flag: enabled lanes disagreed on next_pc
- instr_count  out  16  retired instruction count, saturating

Behaviour:
- State encoding is fixed, because the PC, ALU and LSU units decode it directly:
  - IDLE=000, FETCH=001, DECODE=010, REQUEST=011
  - WAIT=100, EXECUTE=101, UPDATE=110, DONE=111
- Reset values:
  - core_state=IDLE, current_pc=0, done=0, diverged=0, instr_count=0.
  - Latched mask is cleared to 0.
  - Reset has priority in every state, including mid-instruction.
- All outputs are registered and change only on rising clk.
- IDLE:
  - start=1 latches thread_enable into the internal mask and moves to FETCH next cycle.
  - start=0 holds IDLE.
- FETCH: holds until fetch_valid=1, then moves to DECODE. Minimum 1 cycle.
- DECODE: exactly 1 cycle, then REQUEST.
- REQUEST: exactly 1 cycle, then WAIT. LSUs sample their requests in this state.
- WAIT:
  - Each cycle, a lane is busy if it is enabled in the latched mask and its lsu_state is 01 or 10.
  - Moves to EXECUTE the first cycle no enabled lane is busy. Minimum 1 cycle in WAIT.
  - Lanes disabled in the mask are ignored.
- EXECUTE: exactly 1 cycle, then UPDATE. PC units register next_pc on the clock edge that leaves EXECUTE.
- UPDATE (1 cycle):
  - instr_count increments, saturating at 0xFFFF.
  - If decoded_ret=1: move to DONE and set done=1. current_pc is unchanged.
  - Otherwise: current_pc takes next_pc of the lowest-index enabled lane, then move to FETCH.
  - If no lane is enabled, lane 0's next_pc is used.
  - diverged is set if any enabled lane's next_pc differs from the selected value. This check is made in every UPDATE, including RET.
- DONE: terminal. done stays 1 and start is ignored. Only reset exits.
- start asserted outside IDLE has no effect. A mask change after launch has no effect until the next launch.
- current_pc wraps modulo 2^PC_BITS; no overflow flag.
- Minimum instruction period, from FETCH entry with fetch_valid already high and LSUs idle, is 6 cycles: FETCH, DECODE, REQUEST, WAIT, EXECUTE, UPDATE.

Test Plan:
- Basic sequence:
  - Stimulus: THREADS=4, mask=1111, fetch_valid tied high, LSUs 00, all next_pc = current_pc+1, RET on the 3rd instruction.
  - Required: states cycle 001,010,011,100,101,110 three times; current_pc goes 0,1,2; done=1 and core_state=111 after the 3rd UPDATE; instr_count=3; diverged=0.
- Fetch and LSU stalls:
  - Stimulus: fetch_valid low for 4 cycles in FETCH; lane 2 lsu_state=01 for 2 cycles then 10 for 3 cycles then 11.
  - Required: FETCH lasts 5 cycles; WAIT lasts 5 cycles after REQUEST, then EXECUTE.
- Masked lanes:
  - Stimulus: mask=0110, lane 0 lsu_state stuck at 10, lane 0 next_pc=0x55, lanes 1 and 2 next_pc=0x10.
  - Required: WAIT exits after 1 cycle; current_pc=0x10; diverged stays 0.
- Divergence and branch:
  - Stimulus: mask=1111; lanes 0..2 next_pc=0x20, lane 3 next_pc=0x21.
  - Required: current_pc=0x20 after UPDATE; diverged=1 and remains 1 through later instructions.
- Reset mid-operation and spurious start:
  - Stimulus: assert reset during WAIT; release it; pulse start during IDLE, then again during DECODE.
  - Required: all outputs return to reset values the cycle after reset; only the IDLE start launches; the DECODE start is ignored.
- Wrap and saturation:
  - Stimulus: current_pc=0xFF with next_pc=0x00 (8-bit add); preload via run or force instr_count=0xFFFF.
  - Required: current_pc wraps to 0x00; instr_count stays 0xFFFF after the next UPDATE.
